fir_driver: RTL and testbench
=============================

# fir_driver

Upstream sequencer for the `fir` filter block. It holds a host-writable coefficient table and, on `start`, plays the coefficient-load protocol into the filter. It then streams samples from a ready/valid source into the filter and collects the filter results into an output FIFO. A credit counter guarantees the FIFO never overflows. It sits between the system datapath and `fir`, replacing bench-driven `coef_enable`/`sample_enable` sequencing.

## Interface
Parameters:
- `DATA_W`, 8, width of coefficients and samples (matches `fir.data_in`)
- `OUT_W`, 16, width of filter result (matches `fir.data_out`)
- `NUM_TAPS`, 10, coefficients loaded per `start`
- `FIFO_DEPTH`, 8, output FIFO entries (power of two, ≥2)

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous active-high reset
- `start`  in  1  pulse; begin coefficient load (accepted in IDLE or ERR only)
- `stop`  in  1  pulse; end streaming (accepted in STREAM only)
- `coef_wr_en`  in  1  write coefficient table entry
- `coef_wr_addr`  in  clog2(NUM_TAPS)  table index; values ≥ NUM_TAPS ignored
- `coef_wr_data`  in  DATA_W  coefficient value
- `s_valid` / `s_ready` / `s_data`  in / out / in  1 / 1 / DATA_W  sample input stream
- `fir_data_in`  out  DATA_W  to `fir.data_in`
- `fir_coef_enable`  out  1  to `fir.coef_enable`
- `fir_sample_enable`  out  1  to `fir.sample_enable`
- `fir_data_out`  in  OUT_W  from `fir.data_out`
- `fir_out_enable`  in  1  from `fir.out_enable`
- `fir_error`  in  1  from `fir.error`
- `m_valid` / `m_ready` / `m_data`  out / in / out  1 / 1 / OUT_W  result output stream
- `busy`  out  1  state is LOAD, GAP, STREAM or DRAIN
- `err_sticky`  out  1  `fir_error` seen since last accepted `start`
- `overflow`  out  1  sticky; result arrived with FIFO full

## Operation
- States: IDLE, LOAD, GAP, STREAM, DRAIN, ERR.
- Reset: state IDLE. Coef table, FIFO, `inflight` and all outputs are 0.
- Coefficient writes take effect only in IDLE or ERR. Writes in other states are dropped.
- IDLE/ERR, `start` -> LOAD. The transition clears `err_sticky`, `overflow` and `count`.
- LOAD: `fir_coef_enable`=1 and `fir_data_in`=coef[count], with `count` running 0..NUM_TAPS-1. After the last tap -> GAP.
- GAP: exactly one cycle with both enables 0 and `fir_data_in`=0. Then -> STREAM.
- STREAM: `s_ready` = (fifo_count + inflight < FIFO_DEPTH).
  - Handshake `s_valid && s_ready`: the next cycle drives `fir_sample_enable`=1 and `fir_data_in`=s_data, and `inflight`+1.
  - With no handshake, `fir_sample_enable`=0.
- `stop` in STREAM -> DRAIN. `s_ready`=0 in DRAIN. DRAIN -> IDLE when `inflight`==0.
- Every `fir_out_enable`=1 cycle:
  - pushes `fir_data_out` into the FIFO and decrements `inflight` (saturating at 0).
  - If the FIFO is full with no same-cycle pop, the result is dropped and `overflow` is set.
- FIFO: `m_valid` = not empty, `m_data` = head. Pop on `m_valid && m_ready`. Simultaneous push and pop is legal in any occupancy.
- `fir_error`=1 in any non-IDLE state sets `err_sticky` and forces ERR next cycle.
  - ERR: enables 0, `s_ready`=0, `inflight` cleared, FIFO kept readable.
- `start` while in LOAD/GAP/STREAM/DRAIN and `stop` outside STREAM are ignored.

## Timing
- All FIR-side outputs are registered.
- `start` sampled at edge t: `fir_coef_enable` is high for cycles t+1..t+NUM_TAPS, GAP is at t+NUM_TAPS+1, and `s_ready` can first assert at t+NUM_TAPS+2.
- Sample handshake at edge t: `fir_sample_enable` is high at t+1. Sustained throughput is 1 sample/cycle while credit allows.
- Result push at edge t: `m_valid` is visible at t+1.
- `fir_error` sampled at edge t: state is ERR from t+1 and the enables are 0 at t+1.
- `reset` overrides everything, including mid-LOAD or mid-STREAM. The FIR sees both enables 0 the cycle after reset is sampled.

## Test plan
- Load coefs 4..13 via `coef_wr_*`, pulse `start` -> `fir_coef_enable` high for exactly 10 cycles with `fir_data_in` 4,5,...,13, one gap cycle, `busy`=1 throughout.
- Five samples of value 1 with `s_valid` held high, bench FIR model returning results 1 cycle later -> five `fir_sample_enable` pulses on consecutive cycles; five results appear on `m_data` in order.
- `m_ready`=0, FIFO_DEPTH=8, model latency 1 -> exactly 8 samples accepted, then `s_ready`=0. Raising `m_ready` drains 8 entries and `s_ready` reasserts. `overflow` stays 0.
- Model injects an unsolicited `fir_out_enable` with the FIFO full -> `overflow`=1, FIFO content unchanged, next `start` clears the flag.
- `fir_error`=1 on the 3rd LOAD cycle -> ERR next cycle, `fir_coef_enable`=0, `err_sticky`=1. A new `start` reloads all 10 coefs and clears `err_sticky`.
- `reset` asserted mid-STREAM with 2 in flight, then `stop` in IDLE -> all outputs 0, `m_valid`=0, state IDLE, `stop` ignored.

Source files
------------

// File: rtl/fir_driver.sv
// fir_driver: sequencer in front of the fir filter block.
// Holds a host-writable coefficient table and replays it into the filter on
// start. It then forwards ready/valid samples to the filter and buffers the
// filter results in a small output FIFO. A credit check against the FIFO
// space keeps the FIFO from overflowing.
module fir_driver #(
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 16,
    parameter int NUM_TAPS   = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
    input  logic [DATA_W-1:0]           coef_wr_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_W-1:0]           s_data,
    output logic [DATA_W-1:0]           fir_data_in,
    output logic                        fir_coef_enable,
    output logic                        fir_sample_enable,
    input  logic [OUT_W-1:0]            fir_data_out,
    input  logic                        fir_out_enable,
    input  logic                        fir_error,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [OUT_W-1:0]            m_data,
    output logic                        busy,
    output logic                        err_sticky,
    output logic                        overflow
);

    localparam int AW  = $clog2(NUM_TAPS);
    localparam int AWE = AW + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = PW + 2;

    localparam logic [AW-1:0]  LAST_TAP = AW'(NUM_TAPS - 1);
    localparam logic [AWE-1:0] TAPS_EXT = AWE'(NUM_TAPS);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0]  DEPTH_S  = SW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_GAP    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       count_q, count_d;
    logic [DATA_W-1:0]   coef_q [NUM_TAPS];
    logic [DATA_W-1:0]   coef_d [NUM_TAPS];
    logic [DATA_W-1:0]   fir_data_in_q, fir_data_in_d;
    logic                fir_coef_enable_q, fir_coef_enable_d;
    logic                fir_sample_enable_q, fir_sample_enable_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [OUT_W-1:0]    fifo_mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0]    fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       fifo_count_q, fifo_count_d;
    logic                err_sticky_q, err_sticky_d;
    logic                overflow_q, overflow_d;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic credit_ok;
    logic s_ready_int;
    logic s_hs;
    logic err_hit;
    logic table_writable;
    logic dec;

    // FIFO status, credit and handshake qualifiers shared by the next-state logic
    always_comb begin
        fifo_empty     = (fifo_count_q == '0);
        fifo_full      = (fifo_count_q == DEPTH_C);
        pop            = !fifo_empty && m_ready;
        // A result may enter a full FIFO only when the head leaves in the same cycle
        push           = fir_out_enable && (!fifo_full || pop);
        drop           = fir_out_enable && fifo_full && !pop;
        // Every accepted sample reserves a FIFO slot until its result is popped
        credit_ok      = ({1'b0, fifo_count_q} + {1'b0, inflight_q}) < DEPTH_S;
        s_ready_int    = (state_q == S_STREAM) && credit_ok;
        s_hs           = s_valid && s_ready_int;
        err_hit        = fir_error && (state_q != S_IDLE);
        table_writable = (state_q == S_IDLE) || (state_q == S_ERR);
        dec            = fir_out_enable && (inflight_q != '0);
    end

    // Sequencer next state and the registered FIR-side drive values
    always_comb begin
        state_d             = state_q;
        count_d             = count_q;
        fir_coef_enable_d   = 1'b0;
        fir_sample_enable_d = 1'b0;
        fir_data_in_d       = '0;
        err_sticky_d        = err_sticky_q;
        overflow_d          = overflow_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start && !err_hit) begin
                    state_d           = S_LOAD;
                    count_d           = '0;
                    err_sticky_d      = 1'b0;
                    overflow_d        = 1'b0;
                    fir_coef_enable_d = 1'b1;
                    fir_data_in_d     = coef_q[0];
                end
            end
            S_LOAD: begin
                if (count_q == LAST_TAP) begin
                    state_d = S_GAP;
                end else begin
                    count_d           = count_q + 1'b1;
                    fir_coef_enable_d = 1'b1;
                    fir_data_in_d     = coef_q[count_q + 1'b1];
                end
            end
            S_GAP: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (s_hs) begin
                    fir_sample_enable_d = 1'b1;
                    fir_data_in_d       = s_data;
                end
                if (stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end

        // A filter error pre-empts everything and silences the filter inputs
        if (err_hit) begin
            state_d             = S_ERR;
            err_sticky_d        = 1'b1;
            fir_coef_enable_d   = 1'b0;
            fir_sample_enable_d = 1'b0;
            fir_data_in_d       = '0;
        end
    end

    // Count of samples handed to the filter whose result has not yet come back
    always_comb begin
        inflight_d = inflight_q;
        if (s_hs && !dec) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!s_hs && dec) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (err_hit) begin
            inflight_d = '0;
        end
    end

    // Host coefficient writes, only while the table is not being replayed
    always_comb begin
        coef_d = coef_q;
        if (coef_wr_en && table_writable && ({1'b0, coef_wr_addr} < TAPS_EXT)) begin
            coef_d[coef_wr_addr] = coef_wr_data;
        end
    end

    // Output FIFO storage and pointers; depth is a power of two so pointers wrap
    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = fir_data_out;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + 1'b1;
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - 1'b1;
        end
    end

    // State register for all control, table and FIFO contents
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            count_q             <= '0;
            fir_data_in_q       <= '0;
            fir_coef_enable_q   <= 1'b0;
            fir_sample_enable_q <= 1'b0;
            inflight_q          <= '0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            fifo_count_q        <= '0;
            err_sticky_q        <= 1'b0;
            overflow_q          <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_mem_q[j] <= '0;
            end
        end else begin
            state_q             <= state_d;
            count_q             <= count_d;
            fir_data_in_q       <= fir_data_in_d;
            fir_coef_enable_q   <= fir_coef_enable_d;
            fir_sample_enable_q <= fir_sample_enable_d;
            inflight_q          <= inflight_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            fifo_count_q        <= fifo_count_d;
            err_sticky_q        <= err_sticky_d;
            overflow_q          <= overflow_d;
            coef_q              <= coef_d;
            fifo_mem_q          <= fifo_mem_d;
        end
    end

    assign fir_data_in       = fir_data_in_q;
    assign fir_coef_enable   = fir_coef_enable_q;
    assign fir_sample_enable = fir_sample_enable_q;
    assign s_ready           = s_ready_int;
    assign m_valid           = !fifo_empty;
    assign m_data            = fifo_mem_q[rd_ptr_q];
    assign busy              = (state_q == S_LOAD) || (state_q == S_GAP) ||
                               (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign err_sticky        = err_sticky_q;
    assign overflow          = overflow_q;

endmodule

// File: tb/tb_fir_driver.sv
// Directed-plus-random bench for fir_driver. A small filter stand-in answers
// every sample one cycle later with 3*x+5; a queue of expected results, held
// in order of acceptance, provides FIFO contents and the credit prediction.
module tb_fir_driver;

    localparam int DATA_W     = 8;
    localparam int OUT_W      = 16;
    localparam int NUM_TAPS   = 10;
    localparam int FIFO_DEPTH = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              coef_wr_en;
    logic [3:0]        coef_wr_addr;
    logic [DATA_W-1:0] coef_wr_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] fir_data_in;
    logic              fir_coef_enable;
    logic              fir_sample_enable;
    logic [OUT_W-1:0]  fir_data_out;
    logic              fir_out_enable;
    logic              fir_error;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic              busy;
    logic              err_sticky;
    logic              overflow;

    int                checks;
    int                errors;
    logic [DATA_W-1:0] exp_coef [NUM_TAPS];
    logic [OUT_W-1:0]  q [$];
    int                pend;
    logic [DATA_W-1:0] last_sd;
    logic              streaming;
    logic              model_en;
    logic              inj;
    logic [OUT_W-1:0]  inj_data;
    logic              r_sv;
    logic              r_mr;
    logic [DATA_W-1:0] r_d;

    fir_driver #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_TAPS(NUM_TAPS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fir_data_in(fir_data_in), .fir_coef_enable(fir_coef_enable),
        .fir_sample_enable(fir_sample_enable), .fir_data_out(fir_data_out),
        .fir_out_enable(fir_out_enable), .fir_error(fir_error),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err_sticky(err_sticky), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] fres(input logic [DATA_W-1:0] x);
        return OUT_W'(x) * 16'd3 + 16'd5;
    endfunction

    function automatic logic [DATA_W-1:0] rnd8();
        return DATA_W'($urandom);
    endfunction

    // Filter stand-in: one-cycle result latency, plus an injection hook
    always @(negedge clk) begin
        #1;
        fir_out_enable = (fir_sample_enable && model_en) || inj;
        fir_data_out   = inj ? inj_data : fres(fir_data_in);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One streaming cycle: check against the queue model, drive, update model
    task automatic stream_step(input logic sv, input logic [DATA_W-1:0] sd, input logic mr);
        logic exp_rdy;
        logic exp_mv;
        exp_rdy = streaming && (q.size() < FIFO_DEPTH);
        exp_mv  = (q.size() - pend) > 0;
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        chk("m_valid", 32'(m_valid), 32'(exp_mv));
        if (exp_mv) chk("m_data", 32'(m_data), 32'(q[0]));
        chk("sample_en", 32'(fir_sample_enable), 32'(pend));
        if (pend != 0) chk("sample_data", 32'(fir_data_in), 32'(last_sd));
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        if (exp_mv && mr) void'(q.pop_front());
        if (exp_rdy && sv) begin
            q.push_back(fres(sd));
            pend    = 1;
            last_sd = sd;
        end else begin
            pend = 0;
        end
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    // Pulse start and follow the coefficient replay and gap cycle
    task automatic run_load(input int err_at, input int drop_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            chk("load_coef_en", 32'(fir_coef_enable), 32'd1);
            chk("load_data", 32'(fir_data_in), 32'(exp_coef[k]));
            chk("load_busy", 32'(busy), 32'd1);
            chk("load_sample_en", 32'(fir_sample_enable), 32'd0);
            if (k == 0) begin
                chk("start_clr_ovf", 32'(overflow), 32'd0);
                chk("start_clr_err", 32'(err_sticky), 32'd0);
            end
            if (k == drop_at) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = 4'd0;
                coef_wr_data = ~exp_coef[0];
            end
            if (k == err_at) begin
                fir_error = 1'b1;
                tick();
                fir_error  = 1'b0;
                coef_wr_en = 1'b0;
                chk("err_coef_en", 32'(fir_coef_enable), 32'd0);
                chk("err_sticky", 32'(err_sticky), 32'd1);
                chk("err_busy", 32'(busy), 32'd0);
                chk("err_s_ready", 32'(s_ready), 32'd0);
                return;
            end
            tick();
            coef_wr_en = 1'b0;
        end
        chk("gap_coef_en", 32'(fir_coef_enable), 32'd0);
        chk("gap_sample_en", 32'(fir_sample_enable), 32'd0);
        chk("gap_data", 32'(fir_data_in), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_s_ready", 32'(s_ready), 32'd0);
        tick();
        streaming = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; fir_error = 1'b0;
        inj = 1'b0; inj_data = '0; model_en = 1'b1;
        pend = 0; last_sd = '0; streaming = 1'b0;
        r_sv = 1'b0; r_mr = 1'b0; r_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) exp_coef[k] = '0;

        // Reset state
        @(negedge clk);
        tick();
        tick();
        chk("rst_coef_en", 32'(fir_coef_enable), 32'd0);
        chk("rst_sample_en", 32'(fir_sample_enable), 32'd0);
        chk("rst_data_in", 32'(fir_data_in), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;

        // Coefficients 4..13, plus an out-of-range write that must be ignored
        for (int i = 0; i < NUM_TAPS; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'(i);
            coef_wr_data = 8'(4 + i);
            exp_coef[i]  = 8'(4 + i);
            tick();
        end
        coef_wr_addr = 4'd12;
        coef_wr_data = 8'hEE;
        tick();
        coef_wr_en = 1'b0;
        run_load(-1, 3);

        // Five back-to-back samples, then read the five results in order
        for (int i = 0; i < 5; i++) stream_step(1'b1, rnd8(), 1'b0);
        stream_step(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) stream_step(1'b0, '0, 1'b1);

        // Credit limit with the consumer stalled, then drain
        for (int i = 0; i < 12; i++) stream_step(1'b1, rnd8(), 1'b0);
        stream_step(1'b0, '0, 1'b0);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) stream_step(1'b0, '0, 1'b1);

        // Random source and sink pacing
        for (int i = 0; i < 80; i++) begin
            r_sv = 1'($urandom_range(0, 1));
            r_mr = 1'($urandom_range(0, 1));
            r_d  = rnd8();
            stream_step(r_sv, r_d, r_mr);
        end
        for (int i = 0; i < 10; i++) stream_step(1'b0, '0, 1'b1);

        // Unsolicited result into a full FIFO
        for (int i = 0; i < 11; i++) stream_step(1'b1, rnd8(), 1'b0);
        stream_step(1'b0, '0, 1'b0);
        inj_data = 16'hDEAD;
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(m_data), 32'(q[0]));
        for (int i = 0; i < 9; i++) stream_step(1'b0, '0, 1'b1);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Stop -> drain -> idle
        stop = 1'b1;
        streaming = 1'b0;
        tick();
        stop = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_s_ready", 32'(s_ready), 32'd0);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ovf_kept", 32'(overflow), 32'd1);

        // Error on the third load cycle; reload with new table written in ERR
        run_load(2, -1);
        tick();
        chk("err_hold_busy", 32'(busy), 32'd0);
        chk("err_hold_coef_en", 32'(fir_coef_enable), 32'd0);
        for (int i = 0; i < NUM_TAPS; i++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = 4'(i);
            coef_wr_data = rnd8();
            exp_coef[i]  = coef_wr_data;
            tick();
        end
        coef_wr_addr = 4'd15;
        coef_wr_data = rnd8();
        tick();
        coef_wr_en = 1'b0;
        run_load(-1, -1);
        for (int i = 0; i < 4; i++) stream_step(1'b1, rnd8(), 1'b1);
        for (int i = 0; i < 3; i++) stream_step(1'b0, '0, 1'b1);

        // Reset with two samples outstanding, then stop while idle
        model_en = 1'b0;
        chk("pre_rst_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = rnd8();
        tick();
        chk("pre_rst_sample1", 32'(fir_sample_enable), 32'd1);
        s_data = rnd8();
        tick();
        chk("pre_rst_sample2", 32'(fir_sample_enable), 32'd1);
        s_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_sample_en", 32'(fir_sample_enable), 32'd0);
        chk("mid_rst_coef_en", 32'(fir_coef_enable), 32'd0);
        chk("mid_rst_data_in", 32'(fir_data_in), 32'd0);
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_sticky), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
        q.delete();
        pend = 0;
        streaming = 1'b0;
        model_en = 1'b1;
        for (int k = 0; k < NUM_TAPS; k++) exp_coef[k] = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_busy", 32'(busy), 32'd0);
        chk("idle_stop_s_ready", 32'(s_ready), 32'd0);
        chk("idle_stop_sample_en", 32'(fir_sample_enable), 32'd0);

        // Cleared table and cleared in-flight credit after reset
        run_load(-1, -1);
        for (int i = 0; i < 11; i++) stream_step(1'b1, rnd8(), 1'b0);
        stream_step(1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) stream_step(1'b0, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
